fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/rv32_fetch_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 38 +++
 rtl/fetch_pc_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: definitions shared by the fetch PC unit and its hold buffer.
//   fetch_state_t     : fetch FSM encoding (S_RESET, S_WAIT, S_HOLD)
//   NOP_INSTR_ENC     : bubble encoding, addi x0,x0,0
//   RESET_PC_DEFAULT  : default first fetch address after reset
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,  // reset just released, nothing requested yet
    S_WAIT  = 2'd1,  // imem request outstanding
    S_HOLD  = 2'd2   // fetched word parked while decode is stalled
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_ENC    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer for a fetched word that arrived while
// decode was stalled.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture load_word/load_pc, set valid
//   drain         : entry consumed by IF/ID, clear valid
//   flush         : entry discarded (redirect), clear valid
//   valid         : entry holds a word
//   word, pc      : buffered instruction and its address
module fetch_hold_buf
  import rv32_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_word,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] word,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= NOP_INSTR_ENC;
      pc    <= 32'h0;
    end else if (flush || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC generation, single-outstanding instruction fetch and
// the IF/ID pipeline register.
//   clk, rst                 : clock, asynchronous active-high reset
//   branch, branch_target    : redirect from the decode-stage resolver
//   stall                    : decode holds IF/ID this cycle
//   imem_req, imem_addr      : fetch request (level) and aligned address
//   imem_rvalid, imem_rdata  : fetch response
//   code_bus, id_pc, id_valid: IF/ID register
//   dbg_state                : current fetch FSM state (fetch_state_t)
//
// imem handshake: imem_req is a level that stays high, with imem_addr
// stable, from the cycle the request is issued until the cycle that carries
// the matching imem_rvalid (inclusive). A request seen in the cycle after
// that response is a new request. At most one request is outstanding.
module fetch_pc_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] code_bus,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [1:0]  dbg_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  kill_addr_q, kill_addr_d;
  logic         kill_q, kill_d;
  logic [31:0]  code_d, id_pc_d;
  logic         id_valid_d;

  logic         hb_load, hb_drain, hb_flush, hb_valid;
  logic [31:0]  hb_word, hb_pc;

  logic         take_branch;
  logic [31:0]  branch_pc;
  logic [31:0]  pc_inc;

  // Branch is only meaningful when decode actually advances.
  assign take_branch = branch & ~stall;
  assign branch_pc   = {branch_target[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;  // wraps naturally at 2^32

  // While a killed request is still in flight the bus must keep showing
  // its address; the redirected pc is presented once it has returned.
  assign imem_req  = (state_q == S_WAIT);
  assign imem_addr = kill_q ? kill_addr_q : pc_q;
  assign dbg_state = state_q;

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (hb_load),
    .drain     (hb_drain),
    .flush     (hb_flush),
    .load_word (imem_rdata),
    .load_pc   (pc_q),
    .valid     (hb_valid),
    .word      (hb_word),
    .pc        (hb_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      kill_q      <= 1'b0;
      code_bus    <= NOP_INSTR;
      id_pc       <= 32'h0;
      id_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      kill_q      <= kill_d;
      code_bus    <= code_d;
      id_pc       <= id_pc_d;
      id_valid    <= id_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    kill_d      = kill_q;
    code_d      = code_bus;
    id_pc_d     = id_pc;
    id_valid_d  = id_valid;
    hb_load     = 1'b0;
    hb_drain    = 1'b0;
    hb_flush    = 1'b0;

    // Bubble whenever decode advances without a new word; a stall keeps
    // the IF/ID register as is. Branch and delivery cases override below.
    if (!stall) begin
      code_d     = NOP_INSTR;
      id_valid_d = 1'b0;
    end

    case (state_q)
      S_RESET: begin
        // Any imem_rvalid here belongs to a request abandoned by reset.
        state_d = S_WAIT;
        if (take_branch) pc_d = branch_pc;
      end

      S_WAIT: begin
        if (take_branch) begin
          pc_d = branch_pc;
          // A response in this same cycle is simply dropped; otherwise the
          // in-flight response must be swallowed when it arrives.
          kill_d = ~imem_rvalid;
          if (!kill_q) kill_addr_d = pc_q;
        end else if (imem_rvalid && kill_q) begin
          kill_d = 1'b0;
        end else if (imem_rvalid && !stall) begin
          code_d     = imem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_inc;
        end else if (imem_rvalid) begin
          hb_load = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (take_branch) begin
          pc_d     = branch_pc;
          hb_flush = 1'b1;
          state_d  = S_WAIT;
        end else if (!stall && hb_valid) begin
          code_d     = hb_word;
          id_pc_d    = hb_pc;
          id_valid_d = 1'b1;
          hb_drain   = 1'b1;
          pc_d       = pc_inc;
          state_d    = S_WAIT;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors for fetch_pc_unit with a small
// latency-programmable instruction memory model.
module tb_fetch_pc_unit;
  import rv32_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] code_bus;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .code_bus      (code_bus),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory model ----------------
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr_q = 32'h0;

  // Called once per cycle, just after the rising edge: drives this cycle's
  // stimulus and memory response, and accepts a new request if idle.
  task automatic begin_cycle(input logic s, input logic b, input logic [31:0] t, input int lat);
    stall         = s;
    branch        = b;
    branch_target = t;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'hDEAD_BEEF;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_q);
        mem_busy    = 1'b0;
      end
    end else if (imem_req) begin
      mem_busy   = 1'b1;
      mem_cnt    = lat;
      mem_addr_q = imem_addr;
    end
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         stall;
    logic         br;
    logic [31:0]  tgt;
    int           lat;
    logic         req;
    logic [31:0]  addr;
    logic         v;
    logic [31:0]  idpc;
    fetch_state_t st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic b, input logic [31:0] t, input int lat,
                     input logic req, input logic [31:0] addr, input logic v,
                     input logic [31:0] idpc, input fetch_state_t st);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.lat = lat;
    r.req = req; r.addr = addr; r.v = v; r.idpc = idpc; r.st = st;
    vq.push_back(r);
  endtask

  initial begin
    // Expected outputs are those visible during each cycle, before that
    // cycle's inputs take effect.
    //   stall br tgt           lat req addr          v  idpc          state
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,        S_RESET); // 0
    add(0, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,        S_WAIT);  // 1 req 0x0
    add(0, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,        S_WAIT);  // 2 rvalid
    add(0, 0, 32'h0,          1, 1, 32'h4,          1, 32'h0,        S_WAIT);  // 3 req 0x4
    add(0, 0, 32'h0,          1, 1, 32'h4,          0, 32'h0,        S_WAIT);  // 4 rvalid
    add(1, 0, 32'h0,          1, 1, 32'h8,          1, 32'h4,        S_WAIT);  // 5 req 0x8, stall holds
    add(1, 0, 32'h0,          1, 1, 32'h8,          1, 32'h4,        S_WAIT);  // 6 rvalid while stalled
    add(1, 0, 32'h0,          1, 0, 32'h8,          1, 32'h4,        S_HOLD);  // 7
    add(1, 0, 32'h0,          1, 0, 32'h8,          1, 32'h4,        S_HOLD);  // 8
    add(0, 0, 32'h0,          1, 0, 32'h8,          1, 32'h4,        S_HOLD);  // 9 release
    add(0, 0, 32'h0,          1, 1, 32'hC,          1, 32'h8,        S_WAIT);  // 10 req 0xC
    add(0, 0, 32'h0,          1, 1, 32'hC,          0, 32'h0,        S_WAIT);  // 11 rvalid
    add(0, 0, 32'h0,          3, 1, 32'h10,         1, 32'hC,        S_WAIT);  // 12 req 0x10, 3 cycles
    add(0, 1, 32'h103,        1, 1, 32'h10,         0, 32'h0,        S_WAIT);  // 13 branch, no rvalid
    add(0, 0, 32'h0,          1, 1, 32'h10,         0, 32'h0,        S_WAIT);  // 14 killed req in flight
    add(0, 0, 32'h0,          1, 1, 32'h10,         0, 32'h0,        S_WAIT);  // 15 killed rvalid
    add(0, 0, 32'h0,          1, 1, 32'h100,        0, 32'h0,        S_WAIT);  // 16 req 0x100
    add(0, 0, 32'h0,          1, 1, 32'h100,        0, 32'h0,        S_WAIT);  // 17 rvalid
    add(0, 0, 32'h0,          1, 1, 32'h104,        1, 32'h100,      S_WAIT);  // 18 req 0x104
    add(0, 1, 32'h200,        1, 1, 32'h104,        0, 32'h0,        S_WAIT);  // 19 branch + rvalid
    add(0, 0, 32'h0,          1, 1, 32'h200,        0, 32'h0,        S_WAIT);  // 20 req 0x200
    add(0, 1, 32'hFFFF_FFFE,  1, 1, 32'h200,        0, 32'h0,        S_WAIT);  // 21 branch + rvalid
    add(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0,        S_WAIT);  // 22 req top word
    add(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0,        S_WAIT);  // 23 rvalid
    add(0, 0, 32'h0,          1, 1, 32'h0,          1, 32'hFFFF_FFFC, S_WAIT); // 24 wrapped req 0x0
    add(0, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,        S_WAIT);  // 25 rvalid
    add(0, 0, 32'h0,          3, 1, 32'h4,          1, 32'h0,        S_WAIT);  // 26 req 0x4, 3 cycles

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_code",  code_bus, NOP);
    check("rst_idpc",  id_pc, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'(S_RESET));
    end_cycle();
    rst = 1'b0;

    // ---- table-driven run ----
    for (int i = 0; i < vq.size(); i++) begin
      begin_cycle(vq[i].stall, vq[i].br, vq[i].tgt, vq[i].lat);
      check($sformatf("v%0d_req", i),   {31'h0, imem_req}, {31'h0, vq[i].req});
      check($sformatf("v%0d_state", i), {30'h0, dbg_state}, 32'(vq[i].st));
      if (vq[i].req) check($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
      check($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, vq[i].v});
      check($sformatf("v%0d_code", i), code_bus, vq[i].v ? mem_word(vq[i].idpc) : NOP);
      if (vq[i].v) check($sformatf("v%0d_idpc", i), id_pc, vq[i].idpc);
      end_cycle();
    end

    // ---- reset pulse with a request to 0x4 outstanding ----
    rst = 1'b1;
    begin_cycle(0, 0, 32'h0, 1);
    #1;
    check("mid_rst_req",   {31'h0, imem_req}, 32'h0);
    check("mid_rst_addr",  imem_addr, 32'h0);
    check("mid_rst_code",  code_bus, NOP);
    check("mid_rst_valid", {31'h0, id_valid}, 32'h0);
    check("mid_rst_idpc",  id_pc, 32'h0);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    end_cycle();
    rst = 1'b0;
    begin_cycle(0, 0, 32'h0, 1);  // late response lands in S_RESET
    check("late_rvalid_seen", {31'h0, imem_rvalid}, 32'h1);
    check("late_state", {30'h0, dbg_state}, 32'(S_RESET));
    check("late_req",   {31'h0, imem_req}, 32'h0);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    check("post_rst_state", {30'h0, dbg_state}, 32'(S_WAIT));
    check("post_rst_req",   {31'h0, imem_req}, 32'h1);
    check("post_rst_addr",  imem_addr, 32'h0);
    check("post_rst_valid", {31'h0, id_valid}, 32'h0);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    check("post_rst_word", code_bus, mem_word(32'h0));
    check("post_rst_idpc", id_pc, 32'h0);
    check("post_rst_v",    {31'h0, id_valid}, 32'h1);
    check("post_rst_next", imem_addr, 32'h4);
    end_cycle();

    // ---- branch while a word sits in the hold buffer ----
    begin_cycle(1, 0, 32'h0, 1);  // word 0x4 returns while stalled
    end_cycle();
    begin_cycle(0, 1, 32'h41, 1);
    check("hold_br_state", {30'h0, dbg_state}, 32'(S_HOLD));
    check("hold_br_req",   {31'h0, imem_req}, 32'h0);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    check("hold_br_after_state", {30'h0, dbg_state}, 32'(S_WAIT));
    check("hold_br_addr",  imem_addr, 32'h40);
    check("hold_br_valid", {31'h0, id_valid}, 32'h0);
    check("hold_br_code",  code_bus, NOP);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    end_cycle();
    begin_cycle(0, 0, 32'h0, 1);
    check("hold_br_word", code_bus, mem_word(32'h40));
    check("hold_br_idpc", id_pc, 32'h40);
    check("hold_br_v",    {31'h0, id_valid}, 32'h1);
    end_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
